seq_mult_taint_ctrl: RTL

//  Self-contained shift-add sequential multiplier: FSM controller and datapath in one block.

---
 rtl/seq_mult_taint_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_mult_taint_ctrl.sv
// Shift-add sequential multiplier with start/ready/done handshake, optional
// two's-complement mode and constant-time operation. Carries 1-bit taint
// labels for data and control; labels are latched per operation.
module seq_mult_taint_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 start_t,
  input  logic                 signed_mode,
  input  logic                 signed_mode_t,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 multiplier_t,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic                 multiplicand_t,
  output logic                 ready,
  output logic                 done,
  output logic                 done_t,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_t
);

  localparam int unsigned  CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nx;

  logic [WIDTH-1:0]     mr;
  logic [WIDTH-1:0]     md;
  logic [2*WIDTH:0]     sum;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 lbl_d;
  logic                 lbl_c;

  logic                 accept;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH:0]     addend;
  logic [2*WIDTH:0]     sum_step;

  assign ready  = (state == IDLE) || (state == DONE);
  assign done   = (state == DONE);
  assign accept = start && ready;

  // Operand magnitudes and one shift-add iteration; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    a_mag    = multiplier;
    b_mag    = multiplicand;
    addend   = '0;
    sum_step = '0;
    if (signed_mode && multiplier[WIDTH-1]) begin
      a_mag = -multiplier;
    end
    if (signed_mode && multiplicand[WIDTH-1]) begin
      b_mag = -multiplicand;
    end
    if (mr[0]) begin
      addend = {1'b0, md, {WIDTH{1'b0}}};
    end
    sum_step = (sum + addend) >> 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; path through CALC and FIX is independent of operand values.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_nx = FIX;
        end
      end
      FIX: begin
        state_nx = DONE;
      end
      DONE: begin
        if (accept) begin
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath and label registers: load on accept, iterate in CALC, publish in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      mr        <= '0;
      md        <= '0;
      sum       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      lbl_d     <= 1'b0;
      lbl_c     <= 1'b0;
      product   <= '0;
      product_t <= 1'b0;
      done_t    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mr    <= a_mag;
            md    <= b_mag;
            neg   <= signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            sum   <= '0;
            cnt   <= '0;
            lbl_d <= multiplier_t | multiplicand_t | signed_mode_t;
            lbl_c <= start_t | signed_mode_t;
          end
        end
        CALC: begin
          sum <= sum_step;
          mr  <= mr >> 1;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          product   <= neg ? -sum[2*WIDTH-1:0] : sum[2*WIDTH-1:0];
          product_t <= lbl_d | lbl_c;
          done_t    <= lbl_c;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
